// File: rtl/rocket_pool_scheduler.sv
// Rocket slot pool: slot 0 for the player, slots 1..3 shared round-robin by aliens.
// Define ROCKET_COOLDOWN_EN to enable the per-frame player launch cooldown.
module rocket_pool_scheduler #(
  parameter int PLAYER_SPEED           = -256,
  parameter int ALIEN_SPEED            = 128,
  parameter int PLAYER_COOLDOWN_FRAMES = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               playerFireReq,
  input  logic signed [10:0] playerX,
  input  logic signed [10:0] playerY,
  input  logic               alienFireReq,
  input  logic signed [10:0] alienX,
  input  logic signed [10:0] alienY,
  input  logic        [3:0]  reachedBorder,
  input  logic        [3:0]  rocketHit,
  output logic        [3:0]  rocketActive,
  output logic        [43:0] rocketInitX,
  output logic        [43:0] rocketInitY,
  output logic        [43:0] rocketInitSpeed,
  output logic               playerGrant,
  output logic               alienGrant,
  output logic        [2:0]  freeSlots
);

  localparam logic [10:0] P_SPD = 11'(PLAYER_SPEED);
  localparam logic [10:0] A_SPD = 11'(ALIEN_SPEED);
  localparam int CD_W = (PLAYER_COOLDOWN_FRAMES > 1) ? $clog2(PLAYER_COOLDOWN_FRAMES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RETIRE} slot_state_t;

  slot_state_t state_q [4];
  slot_state_t state_d [4];
  logic [43:0] init_x_q, init_x_d, init_y_q, init_y_d, init_spd_q, init_spd_d;
  logic [3:0]  rocket_active_q, rocket_active_d;
  logic        player_grant_q, player_grant_d;
  logic        alien_grant_q, alien_grant_d;
  logic [2:0]  free_slots_q, free_slots_d;
  logic        alien_frame_q, alien_frame_d;
  logic [1:0]  rr_q, rr_d;
  logic        player_take, alien_take, alien_found;
  logic [1:0]  alien_pick, cand;
  logic [CD_W-1:0] cooldown;

`ifdef ROCKET_COOLDOWN_EN
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(PLAYER_COOLDOWN_FRAMES);
  logic [CD_W-1:0] cooldown_q, cooldown_d;

  // A grant reload wins over a same-cycle frame decrement.
  always_comb begin
    cooldown_d = cooldown_q;
    if (startOfFrame && cooldown_q != '0) cooldown_d = cooldown_q - 1'b1;
    if (player_take) cooldown_d = CD_LOAD;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cooldown_q <= '0;
    else         cooldown_q <= cooldown_d;
  end

  assign cooldown = cooldown_q;
`else
  assign cooldown = '0;
`endif

  always_comb begin
    state_d        = state_q;
    init_x_d       = init_x_q;
    init_y_d       = init_y_q;
    init_spd_d     = init_spd_q;
    rr_d           = rr_q;
    player_grant_d = 1'b0;
    alien_grant_d  = 1'b0;
    free_slots_d   = '0;
    alien_found    = 1'b0;
    alien_pick     = 2'd1;
    cand           = 2'd1;

    for (int unsigned n = 0; n < 4; n++) begin
      case (state_q[n])
        S_ACTIVE: if (reachedBorder[n] || rocketHit[n]) state_d[n] = S_RETIRE;
        S_RETIRE: if (startOfFrame) state_d[n] = S_IDLE;
        default:  ;
      endcase
    end

    player_take = playerFireReq && (state_q[0] == S_IDLE) && (cooldown == '0);
    if (player_take) begin
      state_d[0]       = S_ACTIVE;
      init_x_d[10:0]   = playerX;
      init_y_d[10:0]   = playerY;
      init_spd_d[10:0] = P_SPD;
      player_grant_d   = 1'b1;
    end

    // rr_q holds the last granted alien slot; search starts one past it.
    for (int unsigned k = 0; k < 3; k++) begin
      cand = 2'(((32'(rr_q) + k) % 3) + 1);
      if (!alien_found && state_q[cand] == S_IDLE) begin
        alien_found = 1'b1;
        alien_pick  = cand;
      end
    end

    // The per-frame limit is cleared by startOfFrame before this cycle's request is judged.
    alien_take    = alienFireReq && alien_found && (startOfFrame || !alien_frame_q);
    alien_frame_d = alien_take ? 1'b1 : (startOfFrame ? 1'b0 : alien_frame_q);
    if (alien_take) begin
      alien_grant_d = 1'b1;
      rr_d          = alien_pick;
    end
    for (int unsigned n = 1; n < 4; n++) begin
      if (alien_take && alien_pick == 2'(n)) begin
        state_d[n]              = S_ACTIVE;
        init_x_d[11*n +: 11]    = alienX;
        init_y_d[11*n +: 11]    = alienY;
        init_spd_d[11*n +: 11]  = A_SPD;
      end
    end

    for (int unsigned n = 0; n < 4; n++) begin
      rocket_active_d[n] = (state_d[n] == S_ACTIVE);
      if (state_d[n] == S_IDLE) free_slots_d = free_slots_d + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned n = 0; n < 4; n++) state_q[n] <= S_IDLE;
      init_x_q        <= '0;
      init_y_q        <= '0;
      init_spd_q      <= '0;
      rocket_active_q <= '0;
      player_grant_q  <= 1'b0;
      alien_grant_q   <= 1'b0;
      free_slots_q    <= 3'd4;
      alien_frame_q   <= 1'b0;
      rr_q            <= 2'd3;
    end else begin
      state_q         <= state_d;
      init_x_q        <= init_x_d;
      init_y_q        <= init_y_d;
      init_spd_q      <= init_spd_d;
      rocket_active_q <= rocket_active_d;
      player_grant_q  <= player_grant_d;
      alien_grant_q   <= alien_grant_d;
      free_slots_q    <= free_slots_d;
      alien_frame_q   <= alien_frame_d;
      rr_q            <= rr_d;
    end
  end

  assign rocketActive    = rocket_active_q;
  assign rocketInitX     = init_x_q;
  assign rocketInitY     = init_y_q;
  assign rocketInitSpeed = init_spd_q;
  assign playerGrant     = player_grant_q;
  assign alienGrant      = alien_grant_q;
  assign freeSlots       = free_slots_q;

endmodule

// File: tb/tb_rocket_pool_scheduler.sv
// Self-checking bench for rocket_pool_scheduler: directed scenarios plus random traffic vs. a rule-level model.
module tb_rocket_pool_scheduler;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               playerFireReq = 1'b0;
  logic signed [10:0] playerX = '0, playerY = '0;
  logic               alienFireReq = 1'b0;
  logic signed [10:0] alienX = '0, alienY = '0;
  logic        [3:0]  reachedBorder = '0, rocketHit = '0;
  logic        [3:0]  rocketActive;
  logic        [43:0] rocketInitX, rocketInitY, rocketInitSpeed;
  logic               playerGrant, alienGrant;
  logic        [2:0]  freeSlots;

  int checks = 0;
  int failures = 0;

`ifdef ROCKET_COOLDOWN_EN
  localparam int COOLDOWN = 8;
`else
  localparam int COOLDOWN = 0;
`endif

  rocket_pool_scheduler dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .playerFireReq(playerFireReq), .playerX(playerX), .playerY(playerY),
    .alienFireReq(alienFireReq), .alienX(alienX), .alienY(alienY),
    .reachedBorder(reachedBorder), .rocketHit(rocketHit),
    .rocketActive(rocketActive), .rocketInitX(rocketInitX), .rocketInitY(rocketInitY),
    .rocketInitSpeed(rocketInitSpeed), .playerGrant(playerGrant), .alienGrant(alienGrant),
    .freeSlots(freeSlots)
  );

  always #5 clk = ~clk;

  // Model: per slot "in flight" / "waiting for frame" booleans, launch records, bookkeeping ints.
  bit          m_flying [4];
  bit          m_waiting [4];
  logic [10:0] m_x [4], m_y [4], m_spd [4];
  bit          m_pg, m_ag, m_alien_used;
  int          m_last, m_cd;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_flying[i] = 0; m_waiting[i] = 0; m_x[i] = '0; m_y[i] = '0; m_spd[i] = '0;
    end
    m_pg = 0; m_ag = 0; m_alien_used = 0; m_last = 3; m_cd = 0;
  endfunction

  function automatic bit m_idle(int i);
    return !m_flying[i] && !m_waiting[i];
  endfunction

  function automatic void model_step();
    bit was_idle [4];
    bit used;
    int pick;
    for (int i = 0; i < 4; i++) was_idle[i] = m_idle(i);
    m_pg = playerFireReq && was_idle[0] && (m_cd == 0);
    used = startOfFrame ? 0 : m_alien_used;
    pick = 0;
    if (alienFireReq && !used)
      for (int k = 1; k <= 3; k++) begin
        int s = (m_last + k - 1) % 3 + 1;
        if (pick == 0 && was_idle[s]) pick = s;
      end
    m_ag = (pick != 0);
    for (int i = 0; i < 4; i++) begin
      if (m_flying[i] && (reachedBorder[i] || rocketHit[i])) begin
        m_flying[i] = 0; m_waiting[i] = 1;
      end else if (m_waiting[i] && startOfFrame) m_waiting[i] = 0;
    end
    if (m_pg) begin
      m_flying[0] = 1; m_x[0] = playerX; m_y[0] = playerY; m_spd[0] = 11'(-256);
    end
    if (m_ag) begin
      m_flying[pick] = 1; m_x[pick] = alienX; m_y[pick] = alienY; m_spd[pick] = 11'd128;
      m_last = pick;
    end
    m_alien_used = m_ag ? 1 : used;
    if (COOLDOWN != 0) begin
      if (startOfFrame && m_cd > 0) m_cd = m_cd - 1;
      if (m_pg) m_cd = COOLDOWN;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    startOfFrame = 0; playerFireReq = 0; alienFireReq = 0; reachedBorder = '0; rocketHit = '0;
  endtask

  task automatic do_reset();
    #1 resetN = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) resetN = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rocketActive !== 4'b0000) begin failures++; $display("FAIL reset_active got=%b exp=0000", rocketActive); end
    checks++; if (freeSlots !== 3'd4) begin failures++; $display("FAIL reset_free got=%0d exp=4", freeSlots); end
    checks++; if ({playerGrant, alienGrant} !== 2'b00) begin failures++; $display("FAIL reset_grants got=%b exp=00", {playerGrant, alienGrant}); end
    checks++; if ({rocketInitX, rocketInitY, rocketInitSpeed} !== '0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {rocketInitX, rocketInitY, rocketInitSpeed}); end
  endtask

  task automatic test_player();
    do_reset();
    playerFireReq = 1; playerX = 11'sd100; playerY = 11'sd400; tick();
    checks++; if (playerGrant !== 1'b1) begin failures++; $display("FAIL player_grant got=%b exp=1", playerGrant); end
    checks++; if (rocketActive !== 4'b0001) begin failures++; $display("FAIL player_active got=%b exp=0001", rocketActive); end
    checks++; if ({rocketInitX[10:0], rocketInitY[10:0], rocketInitSpeed[10:0]} !== {11'sd100, 11'sd400, -11'sd256})
      begin failures++; $display("FAIL player_fields got=%0d/%0d/%0d exp=100/400/-256", $signed(rocketInitX[10:0]), $signed(rocketInitY[10:0]), $signed(rocketInitSpeed[10:0])); end
    tick();
    checks++; if (playerGrant !== 1'b0) begin failures++; $display("FAIL player_pulse got=%b exp=0", playerGrant); end
    reachedBorder = 4'b0001; tick();
    checks++; if (rocketActive !== 4'b0000) begin failures++; $display("FAIL player_retire got=%b exp=0000", rocketActive); end
    playerFireReq = 1; playerX = 11'sd5; tick();
    checks++; if (playerGrant !== 1'b0) begin failures++; $display("FAIL player_retire_deny got=%b exp=0", playerGrant); end
    checks++; if (rocketInitX[10:0] !== 11'sd100) begin failures++; $display("FAIL player_hold got=%0d exp=100", $signed(rocketInitX[10:0])); end
    // A request landing on the releasing frame edge is still refused.
    startOfFrame = 1; playerFireReq = 1; tick();
    checks++; if (playerGrant !== 1'b0) begin failures++; $display("FAIL player_coincide_deny got=%b exp=0", playerGrant); end
    for (int f = 1; f < COOLDOWN; f++) begin startOfFrame = 1; tick(); end
    playerFireReq = 1; playerX = -11'sd7; tick();
    checks++; if (playerGrant !== 1'b1) begin failures++; $display("FAIL player_regrant got=%b exp=1", playerGrant); end
    checks++; if (rocketInitX[10:0] !== -11'sd7) begin failures++; $display("FAIL player_regrant_x got=%0d exp=-7", $signed(rocketInitX[10:0])); end
  endtask

  task automatic test_alien_round_robin();
    do_reset();
    alienFireReq = 1; alienX = 11'sd33; alienY = -11'sd44; tick();
    checks++; if ({alienGrant, rocketActive} !== 5'b1_0010) begin failures++; $display("FAIL rr_first got=%b exp=1_0010", {alienGrant, rocketActive}); end
    checks++; if ({rocketInitX[21:11], rocketInitY[21:11], rocketInitSpeed[21:11]} !== {11'sd33, -11'sd44, 11'sd128})
      begin failures++; $display("FAIL rr_fields got=%h exp=%h", {rocketInitX[21:11], rocketInitY[21:11], rocketInitSpeed[21:11]}, {11'sd33, -11'sd44, 11'sd128}); end
    alienFireReq = 1; tick();
    checks++; if ({alienGrant, rocketActive} !== 5'b0_0010) begin failures++; $display("FAIL rr_frame_limit got=%b exp=0_0010", {alienGrant, rocketActive}); end
    startOfFrame = 1; tick();
    alienFireReq = 1; tick();
    checks++; if ({alienGrant, rocketActive} !== 5'b1_0110) begin failures++; $display("FAIL rr_second got=%b exp=1_0110", {alienGrant, rocketActive}); end
    startOfFrame = 1; alienFireReq = 1; tick();
    checks++; if ({alienGrant, rocketActive} !== 5'b1_1110) begin failures++; $display("FAIL rr_third_on_sof got=%b exp=1_1110", {alienGrant, rocketActive}); end
    startOfFrame = 1; alienFireReq = 1; tick();
    checks++; if (alienGrant !== 1'b0) begin failures++; $display("FAIL rr_full_deny got=%b exp=0", alienGrant); end
    checks++; if (freeSlots !== 3'd1) begin failures++; $display("FAIL rr_full_free got=%0d exp=1", freeSlots); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    playerFireReq = 1; alienFireReq = 1; tick();
    checks++; if ({playerGrant, alienGrant, rocketActive} !== 6'b11_0011) begin failures++; $display("FAIL simul got=%b exp=11_0011", {playerGrant, alienGrant, rocketActive}); end
    checks++; if (freeSlots !== 3'd2) begin failures++; $display("FAIL simul_free got=%0d exp=2", freeSlots); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    playerFireReq = 1; alienFireReq = 1; tick();
    startOfFrame = 1; alienFireReq = 1; tick();
    startOfFrame = 1; alienFireReq = 1; tick();
    checks++; if (rocketActive !== 4'b1111) begin failures++; $display("FAIL mid_full got=%b exp=1111", rocketActive); end
    resetN = 0; model_reset(); #1;
    checks++; if ({rocketActive, freeSlots} !== 7'b0000_100) begin failures++; $display("FAIL mid_async got=%b/%0d exp=0000/4", rocketActive, freeSlots); end
    checks++; if ({playerGrant, alienGrant} !== 2'b00) begin failures++; $display("FAIL mid_grants got=%b exp=00", {playerGrant, alienGrant}); end
    @(posedge clk); @(negedge clk) resetN = 1; #1;
    alienFireReq = 1; tick();
    checks++; if ({alienGrant, rocketActive} !== 5'b1_0010) begin failures++; $display("FAIL mid_after got=%b exp=1_0010", {alienGrant, rocketActive}); end
  endtask

  task automatic test_random();
    logic [3:0]  e_act;
    logic [43:0] e_x, e_y, e_s;
    logic [2:0]  e_free;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      startOfFrame  = ($urandom_range(0, 5) == 0);
      playerFireReq = ($urandom_range(0, 2) == 0);
      alienFireReq  = ($urandom_range(0, 2) == 0);
      playerX = 11'($urandom); playerY = 11'($urandom);
      alienX  = 11'($urandom); alienY  = 11'($urandom);
      reachedBorder = 4'($urandom) & 4'($urandom);
      rocketHit     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      tick();
      e_free = '0;
      for (int i = 0; i < 4; i++) begin
        e_act[i] = m_flying[i];
        if (m_idle(i)) e_free = e_free + 3'd1;
        e_x[11*i +: 11] = m_x[i]; e_y[11*i +: 11] = m_y[i]; e_s[11*i +: 11] = m_spd[i];
      end
      checks++; if (rocketActive !== e_act) begin failures++; $display("FAIL rnd_active c=%0d got=%b exp=%b", c, rocketActive, e_act); end
      checks++; if ({playerGrant, alienGrant} !== {m_pg, m_ag}) begin failures++; $display("FAIL rnd_grants c=%0d got=%b exp=%b", c, {playerGrant, alienGrant}, {m_pg, m_ag}); end
      checks++; if (freeSlots !== e_free) begin failures++; $display("FAIL rnd_free c=%0d got=%0d exp=%0d", c, freeSlots, e_free); end
      checks++; if ({rocketInitX, rocketInitY, rocketInitSpeed} !== {e_x, e_y, e_s})
        begin failures++; $display("FAIL rnd_fields c=%0d got=%h/%h/%h exp=%h/%h/%h", c, rocketInitX, rocketInitY, rocketInitSpeed, e_x, e_y, e_s); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_player();
    test_alien_round_robin();
    test_simultaneous();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
